// File: rtl/aeolus_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : aeolus_sequencer
// Description : Fetch/decode/execute sequencer driving one-hot control strobes
//               from a 4-bit opcode ROM. Optional single-step input enabled by
//               the AEOLUS_SINGLE_STEP_EN macro.
// Revision    : 1.0
// ============================================================================
module aeolus_sequencer #(
    parameter int PC_WIDTH     = 8,
    parameter bit HALT_ON_WRAP = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                rom_ack,
    input  logic [3:0]          instr,
    input  logic                cond_flag,
`ifdef AEOLUS_SINGLE_STEP_EN
    input  logic                step,
`endif
    output logic                rom_req,
    output logic [PC_WIDTH-1:0] pc,
    output logic [15:0]         ctrl,
    output logic                busy,
    output logic                halted,
    output logic [15:0]         instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t              state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [3:0]          ir_q;
    logic [15:0]         ctrl_q;
    logic [15:0]         count_q;
    logic                rom_req_q;
    logic                busy_q;
    logic                halted_q;

    logic [PC_WIDTH-1:0] pc_d;
    logic [15:0]         count_d;
    logic [15:0]         ctrl_d;
    logic                gate_d;
    logic                start_d;

`ifdef AEOLUS_SINGLE_STEP_EN
    logic step_q;
    // Only a fresh step edge starts an instruction; holding step high does not repeat.
    assign start_d = run | (step & ~step_q);
`else
    assign start_d = run;
`endif

    always_comb begin
        pc_d    = pc_q + PC_WIDTH'(1);
        count_d = (&count_q) ? count_q : count_q + 16'd1;
        gate_d  = ((ir_q == 4'd8) || (ir_q == 4'd9)) ? cond_flag : 1'b1;
        ctrl_d  = gate_d ? (16'h0001 << ir_q) : 16'h0000;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= 4'd0;
            ctrl_q    <= 16'h0000;
            count_q   <= 16'h0000;
            rom_req_q <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
`ifdef AEOLUS_SINGLE_STEP_EN
            step_q    <= 1'b0;
`endif
        end else begin
`ifdef AEOLUS_SINGLE_STEP_EN
            step_q <= step;
`endif
            case (state_q)
                S_IDLE: begin
                    if (start_d) begin
                        state_q   <= S_FETCH;
                        rom_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (rom_ack) begin
                        ir_q      <= instr;
                        state_q   <= S_DECODE;
                        rom_req_q <= 1'b0;
                    end
                end
                S_DECODE: begin
                    // The conditional gate is folded straight into the strobe register.
                    ctrl_q  <= ctrl_d;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    ctrl_q  <= 16'h0000;
                    count_q <= count_d;
                    if ((&pc_q) && HALT_ON_WRAP) begin
                        state_q  <= S_HALT;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        pc_q <= pc_d;
                        if (run) begin
                            state_q   <= S_FETCH;
                            rom_req_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q   <= S_IDLE;
                    ctrl_q    <= 16'h0000;
                    rom_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                    halted_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rom_req     = rom_req_q;
    assign pc          = pc_q;
    assign ctrl        = ctrl_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_aeolus_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aeolus_sequencer
// Description : Directed, table-driven bench for aeolus_sequencer.
// Revision    : 1.0
// ============================================================================
module tb_aeolus_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        rom_ack;
    logic        cond_flag;
    logic [3:0]  instr;
    logic [3:0]  instr_w;
    logic        rom_req, busy, halted;
    logic [7:0]  pc;
    logic [15:0] ctrl, instr_count;
    logic        rom_req_w, busy_w, halted_w;
    logic [1:0]  pc_w;
    logic [15:0] ctrl_w, instr_count_w;
    logic [3:0]  rom [256];
`ifdef AEOLUS_SINGLE_STEP_EN
    logic        step;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign instr   = rom[pc];
    assign instr_w = rom[{6'd0, pc_w}];

    aeolus_sequencer #(.PC_WIDTH(8), .HALT_ON_WRAP(1'b1)) dut (
        .clk(clk), .reset(reset), .run(run), .rom_ack(rom_ack), .instr(instr),
        .cond_flag(cond_flag),
`ifdef AEOLUS_SINGLE_STEP_EN
        .step(step),
`endif
        .rom_req(rom_req), .pc(pc), .ctrl(ctrl), .busy(busy), .halted(halted),
        .instr_count(instr_count)
    );

    aeolus_sequencer #(.PC_WIDTH(2), .HALT_ON_WRAP(1'b0)) dut_w (
        .clk(clk), .reset(reset), .run(run), .rom_ack(rom_ack), .instr(instr_w),
        .cond_flag(cond_flag),
`ifdef AEOLUS_SINGLE_STEP_EN
        .step(step),
`endif
        .rom_req(rom_req_w), .pc(pc_w), .ctrl(ctrl_w), .busy(busy_w), .halted(halted_w),
        .instr_count(instr_count_w)
    );

    typedef struct {
        logic        run, ack, cond;
        logic        req;
        logic [7:0]  pc;
        logic [15:0] ctrl;
        logic        busy, halted;
        logic [15:0] cnt;
    } vec_t;

    vec_t tv [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; run = 1'b0; rom_ack = 1'b0; cond_flag = 1'b0;
`ifdef AEOLUS_SINGLE_STEP_EN
        step = 1'b0;
`endif
        tick(); tick();
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 4'd7;
        rom[0] = 4'd0; rom[1] = 4'd1; rom[2] = 4'd10; rom[3] = 4'd2;
        rom[4] = 4'd8; rom[5] = 4'd8;

        //         run ack cond  req pc    ctrl      busy hlt cnt
        tv[0]  = '{1, 1, 0,  1, 8'd0, 16'h0000, 1, 0, 16'd0};
        tv[1]  = '{1, 1, 0,  0, 8'd0, 16'h0000, 1, 0, 16'd0};
        tv[2]  = '{1, 1, 0,  0, 8'd0, 16'h0001, 1, 0, 16'd0};
        tv[3]  = '{1, 1, 0,  1, 8'd1, 16'h0000, 1, 0, 16'd1};
        tv[4]  = '{1, 1, 0,  0, 8'd1, 16'h0000, 1, 0, 16'd1};
        tv[5]  = '{1, 1, 0,  0, 8'd1, 16'h0002, 1, 0, 16'd1};
        tv[6]  = '{1, 1, 0,  1, 8'd2, 16'h0000, 1, 0, 16'd2};
        tv[7]  = '{1, 1, 0,  0, 8'd2, 16'h0000, 1, 0, 16'd2};
        tv[8]  = '{1, 1, 0,  0, 8'd2, 16'h0400, 1, 0, 16'd2};
        tv[9]  = '{1, 1, 0,  1, 8'd3, 16'h0000, 1, 0, 16'd3};
        tv[10] = '{1, 1, 0,  0, 8'd3, 16'h0000, 1, 0, 16'd3};
        tv[11] = '{0, 1, 0,  0, 8'd3, 16'h0004, 1, 0, 16'd3};
        tv[12] = '{0, 1, 0,  0, 8'd4, 16'h0000, 0, 0, 16'd4};
        tv[13] = '{0, 1, 0,  0, 8'd4, 16'h0000, 0, 0, 16'd4};

        reset = 1'b0; run = 1'b0; rom_ack = 1'b0; cond_flag = 1'b0;
`ifdef AEOLUS_SINGLE_STEP_EN
        step = 1'b0;
`endif
        repeat (3) tick();
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_ctrl", 32'(ctrl), 32'd0);
        chk("rst_req", 32'(rom_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_cnt", 32'(instr_count), 32'd0);
        reset = 1'b1;
        tick();
        chk("idle_no_run_req", 32'(rom_req), 32'd0);
        chk("idle_no_run_busy", 32'(busy), 32'd0);

        // Basic run with run dropped during the last DECODE
        for (int i = 0; i < 14; i++) begin
            run = tv[i].run; rom_ack = tv[i].ack; cond_flag = tv[i].cond;
            tick();
            chk($sformatf("tv%0d_req", i), 32'(rom_req), 32'(tv[i].req));
            chk($sformatf("tv%0d_pc", i), 32'(pc), 32'(tv[i].pc));
            chk($sformatf("tv%0d_ctrl", i), 32'(ctrl), 32'(tv[i].ctrl));
            chk($sformatf("tv%0d_busy", i), 32'(busy), 32'(tv[i].busy));
            chk($sformatf("tv%0d_halted", i), 32'(halted), 32'(tv[i].halted));
            chk($sformatf("tv%0d_cnt", i), 32'(instr_count), 32'(tv[i].cnt));
        end

        // Wait states on the fetch at pc=2, then the conditional opcodes
        do_reset();
        run = 1'b1; rom_ack = 1'b1;
        repeat (6) tick();
        rom_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("wait%0d_req", i), 32'(rom_req), 32'd1);
            chk($sformatf("wait%0d_pc", i), 32'(pc), 32'd2);
            chk($sformatf("wait%0d_ctrl", i), 32'(ctrl), 32'd0);
        end
        rom_ack = 1'b1;
        tick(); chk("wait_dec_ctrl", 32'(ctrl), 32'd0);
        tick(); chk("wait_exec_ctrl", 32'(ctrl), 32'h0400);
        tick(); tick(); tick(); chk("pc3_ctrl", 32'(ctrl), 32'h0004);
        tick(); chk("pc4_fetch", 32'(pc), 32'd4);
        cond_flag = 1'b0;
        tick(); tick(); chk("snza_c0_ctrl", 32'(ctrl), 32'd0);
        tick();
        chk("snza_c0_pc", 32'(pc), 32'd5);
        chk("snza_c0_cnt", 32'(instr_count), 32'd5);
        cond_flag = 1'b1;
        tick(); tick(); chk("snza_c1_ctrl", 32'(ctrl), 32'h0100);
        tick();
        chk("snza_c1_pc", 32'(pc), 32'd6);
        chk("snza_c1_cnt", 32'(instr_count), 32'd6);

        // Asynchronous reset mid-FETCH and mid-EXEC
        do_reset();
        run = 1'b1; rom_ack = 1'b0;
        tick(); chk("midf_req_before", 32'(rom_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("midf_req", 32'(rom_req), 32'd0);
        chk("midf_pc", 32'(pc), 32'd0);
        chk("midf_busy", 32'(busy), 32'd0);
        tick(); reset = 1'b1; rom_ack = 1'b1;
        tick(); tick(); tick();
        chk("mide_ctrl_before", 32'(ctrl), 32'h0001);
        #2 reset = 1'b0;
        #1;
        chk("mide_ctrl", 32'(ctrl), 32'd0);
        tick();

        // PC wrap: HALT on the 8-bit instance, continue on the 2-bit instance
        do_reset();
        run = 1'b1; rom_ack = 1'b1;
        repeat (768) tick();
        chk("wrap_exec_halted", 32'(halted), 32'd0);
        chk("wrap_exec_ctrl", 32'(ctrl), 32'h0080);
        chk("wrap_exec_pc", 32'(pc), 32'd255);
        tick();
        chk("wrap_halted", 32'(halted), 32'd1);
        chk("wrap_pc", 32'(pc), 32'd255);
        chk("wrap_busy", 32'(busy), 32'd0);
        chk("wrap_req", 32'(rom_req), 32'd0);
        chk("wrap_cnt", 32'(instr_count), 32'd256);
        chk("wrap0_pc", 32'(pc_w), 32'd0);
        chk("wrap0_cnt", 32'(instr_count_w), 32'd256);
        chk("wrap0_busy", 32'(busy_w), 32'd1);
        chk("wrap0_halted", 32'(halted_w), 32'd0);
        for (int i = 0; i < 6; i++) begin
            run = ~run; rom_ack = ~rom_ack;
            tick();
        end
        chk("halt_hold_halted", 32'(halted), 32'd1);
        chk("halt_hold_pc", 32'(pc), 32'd255);
        chk("halt_hold_req", 32'(rom_req), 32'd0);
        chk("halt_hold_cnt", 32'(instr_count), 32'd256);
        do_reset();
        chk("halt_reset_halted", 32'(halted), 32'd0);
        chk("halt_reset_pc", 32'(pc), 32'd0);

`ifdef AEOLUS_SINGLE_STEP_EN
        do_reset();
        rom_ack = 1'b1; run = 1'b0;
        for (int s = 0; s < 2; s++) begin
            step = 1'b1;
            tick(); chk($sformatf("step%0d_req", s), 32'(rom_req), 32'd1);
            tick(); tick(); tick();
            chk($sformatf("step%0d_idle", s), 32'(busy), 32'd0);
            chk($sformatf("step%0d_cnt", s), 32'(instr_count), 32'(s + 1));
            step = 1'b0;
            tick();
        end
        repeat (4) tick();
        chk("step_hold_cnt", 32'(instr_count), 32'd2);
        chk("step_hold_busy", 32'(busy), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aeolus_sequencer.md
AEOLUS_SEQUENCER -- requirements
Module: aeolus_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 8: width of the program counter and ROM address.
REQ-002 Parameter HALT_ON_WRAP, default 1: 1 enters HALT on PC wrap; 0 wraps PC to 0 and continues.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port run, input, 1: level; 1 lets the sequencer fetch and execute continuously.
REQ-006 Port rom_req, output, 1: fetch request to the program ROM.
REQ-007 Port rom_ack, input, 1: ROM data valid; sampled only while rom_req=1.
REQ-008 Port pc, output, PC_WIDTH: current fetch address.
REQ-009 Port instr, input, 4: opcode from the ROM; captured when rom_req=1 and rom_ack=1.
REQ-010 Port cond_flag, input, 1: ALU shift flag used by the conditional opcodes.
REQ-011 Port ctrl, output, 16: one-hot control strobes; bit n corresponds to opcode n.
REQ-012 Port busy, output, 1: 1 in any state other than IDLE and HALT.
REQ-013 Port halted, output, 1: 1 in HALT.
REQ-014 Port instr_count, output, 16: count of instructions retired, saturating.

Function
REQ-015 The opcode map SHALL be as follows: 0 LDA, 1 LDB, 2 LDO, 3 LDSA, 4 LDSB, 5 LSH, 6 RSH, 7 CLR, 8 SNZA, 9 SNZS, 10 ADD, 11 SUB, 12 AND, 13 OR, 14 XOR, 15 INV.
REQ-016 The FSM SHALL have the states IDLE, FETCH, DECODE, EXEC and HALT.
REQ-017 IDLE SHALL go to FETCH on the first edge with run=1.
REQ-018 FETCH SHALL hold rom_req=1 with pc stable until rom_ack=1.
- On that edge, the FSM latches instr into the instruction register and goes to DECODE.
- The FSM waits with no timeout.
REQ-019 DECODE SHALL last one cycle and SHALL sample cond_flag into a gate bit.
- The gate bit is 1 for opcodes other than 8 and 9.
REQ-020 EXEC SHALL last one cycle and SHALL assert ctrl[IR]=1 only if the gate is 1; otherwise ctrl SHALL be all-zero (a NOP).
REQ-021 ctrl SHALL be all-zero in every state other than EXEC; at most one bit SHALL ever be 1.
REQ-022 On leaving EXEC, pc SHALL increment by 1 and instr_count SHALL increment, holding at 16'hFFFF.
REQ-023 EXEC SHALL go to FETCH if run=1, otherwise to IDLE; run falling mid-instruction SHALL NOT abort the instruction.
REQ-024 Minimum instruction latency SHALL be 3 cycles (rom_ack=1 in the first FETCH cycle); each extra wait cycle adds 1.
REQ-025 PC wrap: when EXEC completes at pc = all-ones, the behaviour SHALL depend on HALT_ON_WRAP.
- HALT_ON_WRAP=1: go to HALT with pc held at all-ones.
- HALT_ON_WRAP=0: pc becomes 0 and sequencing continues.
REQ-026 HALT SHALL be left only by reset; run and rom_ack SHALL be ignored in HALT.
REQ-027 rom_ack=1 while rom_req=0 SHALL have no effect.

Reset
REQ-028 While reset=0 the block SHALL be in IDLE, and the outputs SHALL be as follows:
- pc=0, ctrl=0, rom_req=0, busy=0, halted=0.
- instr_count=0 and the instruction register = 0.
REQ-029 Reset asserted mid-FETCH or mid-EXEC SHALL drop rom_req and ctrl asynchronously, within the same cycle.
REQ-030 After reset release, the first fetch SHALL occur no earlier than the first edge with run=1.

Configuration
REQ-031 Macro AEOLUS_SINGLE_STEP_EN SHALL add an input port step (1 bit).
- A rising edge on step, detected by a register, while in IDLE with run=0 SHALL execute exactly one instruction and return to IDLE.
- A step edge in any other state SHALL be ignored.
REQ-032 Without AEOLUS_SINGLE_STEP_EN, the step port and its edge register SHALL NOT exist, and IDLE SHALL be left only via run=1.

Verification
REQ-033 Basic run: reset, run=1, ROM {0,1,10,2}, rom_ack tied 1 -> ctrl pulses 0x0001, 0x0002, 0x0400, 0x0004 every 3 cycles; instr_count=4.
REQ-034 Wait states: rom_ack delayed 4 cycles on the fetch at pc=2 -> pc stays 2 and rom_req stays 1 for 5 cycles; no ctrl pulse in between.
REQ-035 Conditional: opcode 8 with cond_flag=0 -> ctrl=0 in EXEC, pc+1, instr_count+1; with cond_flag=1 -> ctrl=0x0100.
REQ-036 Wrap: HALT_ON_WRAP=1, start at pc=255 -> after EXEC halted=1, pc=255, busy=0; run toggles are ignored until reset.
REQ-037 Mid-operation: run=0 asserted during DECODE -> EXEC completes, then IDLE; reset=0 mid-FETCH -> rom_req=0 immediately, pc=0.
REQ-038 With AEOLUS_SINGLE_STEP_EN: run=0, two step pulses -> exactly two instructions retire, and the FSM is in IDLE after each.
